// File: rtl/multi_fluid_dispense_ctrl.sv
// multi_fluid_dispense_ctrl: request/response dispense controller with per-channel
// stock, two-tier per-channel pricing, loyalty discount from a per-user visit table
// and an independent refill port. Stock and visit updates commit together.
// Optional build macro LOW_STOCK_ALARM_EN adds LOW_THRESH and the low_stock output.
module multi_fluid_dispense_ctrl #(
    parameter int NUM_FLUIDS = 4,
    parameter int NUM_USERS  = 16,
    parameter int VOL_W      = 8,
    parameter int STOCK_W    = 16,
    parameter int RATE_W     = 8,
    parameter int PRICE_W    = 16,
    parameter logic [NUM_FLUIDS*RATE_W-1:0]  FIRST_RATE = {8'd30, 8'd40, 8'd50, 8'd20},
    parameter logic [NUM_FLUIDS*RATE_W-1:0]  EXTRA_RATE = {8'd15, 8'd20, 8'd30, 8'd10},
    parameter logic [NUM_FLUIDS*STOCK_W-1:0] INIT_STOCK = {16'd50, 16'd60, 16'd80, 16'd100},
`ifdef LOW_STOCK_ALARM_EN
    parameter int LOW_THRESH = 10,
`endif
    localparam int CH_W   = $clog2(NUM_FLUIDS),
    localparam int USER_W = $clog2(NUM_USERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [USER_W-1:0]  req_user,
    input  logic [CH_W-1:0]    req_fluid,
    input  logic [VOL_W-1:0]   req_vol,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [1:0]         resp_status,
    output logic [PRICE_W-1:0] resp_orig_price,
    output logic [PRICE_W-1:0] resp_final_price,
    output logic [7:0]         resp_discount,
    output logic [STOCK_W-1:0] resp_remaining,
    output logic [7:0]         resp_visits,
    input  logic               refill_valid,
    input  logic [CH_W-1:0]    refill_ch,
    input  logic [STOCK_W-1:0] refill_qty
`ifdef LOW_STOCK_ALARM_EN
    ,
    output logic [NUM_FLUIDS-1:0] low_stock
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    // Channel count widened by one bit so out-of-range ids compare cleanly.
    localparam logic [CH_W:0] NF = NUM_FLUIDS[CH_W:0];

    state_t state, state_nx;

    logic [USER_W-1:0]  cap_user;
    logic [CH_W-1:0]    cap_fluid;
    logic [VOL_W-1:0]   cap_vol;

    logic [STOCK_W-1:0] stock    [NUM_FLUIDS];
    logic [STOCK_W-1:0] stock_nx [NUM_FLUIDS];
    logic [7:0]         visits   [NUM_USERS];

    logic [STOCK_W-1:0] sel_stock, remaining_nx;
    logic [RATE_W-1:0]  first, extra;
    logic               ch_ok, commit;
    logic [1:0]         status;
    logic [7:0]         vis_old, vis_new, pct;
    logic [PRICE_W-1:0] orig, fin;

    function automatic logic [7:0] disc_pct(input logic [7:0] v);
        if (v <= 8'd2)      return 8'd0;
        else if (v <= 8'd4) return 8'd10;
        else                return 8'd20;
    endfunction

    // Truncating percentage discount: p - floor(p*pct/100).
    function automatic logic [PRICE_W-1:0] apply_disc(input logic [PRICE_W-1:0] p,
                                                      input logic [7:0] d);
        logic [PRICE_W+6:0] prod;
        prod = (PRICE_W+7)'(p) * (PRICE_W+7)'(d);
        return p - PRICE_W'(prod / (PRICE_W+7)'(100));
    endfunction

    function automatic logic [STOCK_W-1:0] sat_add(input logic [STOCK_W-1:0] a,
                                                   input logic [STOCK_W-1:0] b);
        logic [STOCK_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STOCK_W] ? '1 : s[STOCK_W-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = CALC;
            end
            CALC: state_nx = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request on the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_user  <= '0;
            cap_fluid <= '0;
            cap_vol   <= '0;
        end else if (state == IDLE && req_valid) begin
            cap_user  <= req_user;
            cap_fluid <= req_fluid;
            cap_vol   <= req_vol;
        end
    end

    // Status, price and discount of the captured request against current stock.
    always_comb begin
        sel_stock = '0;
        first     = '0;
        extra     = '0;
        for (int i = 0; i < NUM_FLUIDS; i++) begin
            if (cap_fluid == i[CH_W-1:0]) begin
                sel_stock = stock[i];
                first     = FIRST_RATE[i*RATE_W +: RATE_W];
                extra     = EXTRA_RATE[i*RATE_W +: RATE_W];
            end
        end
        ch_ok = {1'b0, cap_fluid} < NF;
        if (!ch_ok)                             status = 2'd2;
        else if (cap_vol == '0)                 status = 2'd3;
        else if (sel_stock < STOCK_W'(cap_vol)) status = 2'd1;
        else                                    status = 2'd0;
        vis_old = visits[cap_user];
        pct     = disc_pct(vis_old);
        orig    = '0;
        if (status == 2'd0)
            orig = PRICE_W'(first) + PRICE_W'(cap_vol - VOL_W'(1)) * PRICE_W'(extra);
        fin     = apply_disc(orig, pct);
        commit  = (state == CALC) && (status == 2'd0);
        vis_new = vis_old;
        if (commit && vis_old != 8'hFF) vis_new = vis_old + 8'd1;
    end

    // Next stock: commit subtracts first, then a same-cycle refill adds with saturation.
    always_comb begin
        remaining_nx = '0;
        for (int i = 0; i < NUM_FLUIDS; i++) begin
            stock_nx[i] = stock[i];
            if (commit && cap_fluid == i[CH_W-1:0])
                stock_nx[i] = stock_nx[i] - STOCK_W'(cap_vol);
            if (refill_valid && refill_ch == i[CH_W-1:0])
                stock_nx[i] = sat_add(stock_nx[i], refill_qty);
            if (cap_fluid == i[CH_W-1:0])
                remaining_nx = stock_nx[i];
        end
    end

    // Stock and visit table updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLUIDS; i++)
                stock[i] <= INIT_STOCK[i*STOCK_W +: STOCK_W];
            for (int u = 0; u < NUM_USERS; u++)
                visits[u] <= '0;
        end else begin
            for (int i = 0; i < NUM_FLUIDS; i++)
                stock[i] <= stock_nx[i];
            if (commit) visits[cap_user] <= vis_new;
        end
    end

    // Response fields load once per transaction and hold until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_status      <= '0;
            resp_orig_price  <= '0;
            resp_final_price <= '0;
            resp_discount    <= '0;
            resp_remaining   <= '0;
            resp_visits      <= '0;
        end else if (state == CALC) begin
            resp_status      <= status;
            resp_orig_price  <= orig;
            resp_final_price <= fin;
            resp_discount    <= pct;
            resp_remaining   <= remaining_nx;
            resp_visits      <= vis_new;
        end
    end

`ifdef LOW_STOCK_ALARM_EN
    // Low-stock flags follow the stock registers by one cycle.
    always_ff @(posedge clk) begin
        if (reset) low_stock <= '0;
        else
            for (int i = 0; i < NUM_FLUIDS; i++)
                low_stock[i] <= stock[i] < STOCK_W'(LOW_THRESH);
    end
`endif

endmodule
